// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - shared FIFO read-port bus between the arbiter, the FIFO and its consumers
interface fifo_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  r_en;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    rdy;
    logic [NUM_REQ-1:0]    gnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    modport master (
        input  empty, rdata, req, rdy,
        output r_en, gnt, out_valid, out_data, out_id, busy
    );

    modport slave (
        output empty, rdata, req, rdy,
        input  r_en, gnt, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(BURST_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    g_q;
    logic [ID_W-1:0]    last_gnt_q;
    logic [CNT_W-1:0]   count_q;
    logic               out_valid_q;
    logic [ID_W-1:0]    out_id_q;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;
    logic               r_en;
    logic               burst_exit;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_gnt_q) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        r_en       = 1'b0;
        burst_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.empty && win_found) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                r_en       = !rrst && !bus.empty && bus.req[g_q] && bus.rdy[g_q];
                burst_exit = (r_en && (count_q == CNT_LAST)) || !bus.req[g_q] || bus.empty;
                if (burst_exit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            g_q         <= '0;
            count_q     <= '0;
            last_gnt_q  <= ID_W'(NUM_REQ - 1);
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= r_en;
            // g_q is still the owner on the exit edge, so the last read keeps its id.
            out_id_q    <= g_q;
            if (state_q == IDLE) begin
                if (state_d == BURST) begin
                    gnt_q   <= NUM_REQ'(1) << win_idx;
                    g_q     <= win_idx;
                    count_q <= '0;
                end
            end else begin
                if (r_en && (count_q < CNT_TOP)) begin
                    count_q <= count_q + 1'b1;
                end
                if (burst_exit) begin
                    gnt_q      <= '0;
                    last_gnt_q <= g_q;
                end
            end
        end
    end

    assign bus.r_en      = r_en;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = bus.rdata[DATA_WIDTH-1:0];
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - directed and randomized checks of fifo_rd_arbiter against a FIFO model
module tb_fifo_rd_arbiter;
    logic        rclk = 1'b0;
    logic        rrst;
    int          tests = 0;
    int          fails = 0;
    int unsigned pushed = 0;
    int unsigned popped = 0;
    int          run_len;

    fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    // FIFO model: word n read out carries value n + 0x30, one cycle after r_en.
    assign bus.empty = (pushed == popped);
    always @(posedge rclk) begin
        if (bus.r_en) begin
            bus.rdata <= 8'(popped + 32'h30);
            popped    <= popped + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge rclk);
        #1;
    endtask

    initial begin
        rrst    = 1'b1;
        bus.req = 4'b1111;
        bus.rdy = 4'b1111;
        pushed  = 16;
        nc();
        nc();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_id", 32'(bus.out_id), 32'h0);
        chk("rst_ren", 32'(bus.r_en), 32'h0);
        rrst = 1'b0;

        // Four full bursts in order 0..3 with one idle cycle between them
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                nc();
                chk("rr_gnt", 32'(bus.gnt), 32'(1) << b);
                chk("rr_ren", 32'(bus.r_en), 32'h1);
                chk("rr_busy", 32'(bus.busy), 32'h1);
                if (k == 0) begin
                    chk("rr_valid0", 32'(bus.out_valid), 32'h0);
                end else begin
                    chk("rr_valid", 32'(bus.out_valid), 32'h1);
                    chk("rr_id", 32'(bus.out_id), 32'(b));
                    chk("rr_data", 32'(bus.out_data), 32'h30 + 32'(4 * b + k - 1));
                end
            end
            nc();
            chk("gap_gnt", 32'(bus.gnt), 32'h0);
            chk("gap_ren", 32'(bus.r_en), 32'h0);
            chk("gap_busy", 32'(bus.busy), 32'h0);
            chk("gap_valid", 32'(bus.out_valid), 32'h1);
            chk("gap_id", 32'(bus.out_id), 32'(b));
            chk("gap_data", 32'(bus.out_data), 32'h30 + 32'(4 * b + 3));
        end
        chk("rr_popped", popped, 32'd16);
        chk("rr_empty", 32'(bus.empty), 32'h1);

        // Lone requester 2, burst cut short by an empty FIFO
        bus.req = 4'b0100;
        pushed  = 18;
        nc();
        chk("e_gnt", 32'(bus.gnt), 32'h4);
        chk("e_ren0", 32'(bus.r_en), 32'h1);
        chk("e_valid0", 32'(bus.out_valid), 32'h0);
        nc();
        chk("e_ren1", 32'(bus.r_en), 32'h1);
        chk("e_valid1", 32'(bus.out_valid), 32'h1);
        chk("e_id1", 32'(bus.out_id), 32'h2);
        chk("e_data1", 32'(bus.out_data), 32'h40);
        nc();
        chk("e_ren_empty", 32'(bus.r_en), 32'h0);
        chk("e_gnt_hold", 32'(bus.gnt), 32'h4);
        chk("e_valid2", 32'(bus.out_valid), 32'h1);
        chk("e_id2", 32'(bus.out_id), 32'h2);
        chk("e_data2", 32'(bus.out_data), 32'h41);
        nc();
        chk("e_end_gnt", 32'(bus.gnt), 32'h0);
        chk("e_end_busy", 32'(bus.busy), 32'h0);
        chk("e_end_valid", 32'(bus.out_valid), 32'h0);
        chk("e_popped", popped, 32'd18);

        // Consumer 1 stalls three cycles mid-burst
        bus.req = 4'b0010;
        pushed  = 26;
        nc();
        chk("s_gnt", 32'(bus.gnt), 32'h2);
        chk("s_ren0", 32'(bus.r_en), 32'h1);
        nc();
        chk("s_ren1", 32'(bus.r_en), 32'h1);
        chk("s_data1", 32'(bus.out_data), 32'h42);
        nc();
        bus.rdy = 4'b1101;
        #1;
        chk("s_stall1_ren", 32'(bus.r_en), 32'h0);
        chk("s_stall1_gnt", 32'(bus.gnt), 32'h2);
        chk("s_data2", 32'(bus.out_data), 32'h43);
        nc();
        chk("s_stall2_ren", 32'(bus.r_en), 32'h0);
        chk("s_stall2_gnt", 32'(bus.gnt), 32'h2);
        chk("s_stall2_valid", 32'(bus.out_valid), 32'h0);
        nc();
        chk("s_stall3_ren", 32'(bus.r_en), 32'h0);
        chk("s_stall3_gnt", 32'(bus.gnt), 32'h2);
        nc();
        bus.rdy = 4'b1111;
        #1;
        chk("s_resume_ren", 32'(bus.r_en), 32'h1);
        chk("s_resume_gnt", 32'(bus.gnt), 32'h2);
        nc();
        chk("s_ren4", 32'(bus.r_en), 32'h1);
        chk("s_data3", 32'(bus.out_data), 32'h44);
        nc();
        chk("s_end_gnt", 32'(bus.gnt), 32'h0);
        chk("s_end_busy", 32'(bus.busy), 32'h0);
        chk("s_end_valid", 32'(bus.out_valid), 32'h1);
        chk("s_end_id", 32'(bus.out_id), 32'h1);
        chk("s_end_data", 32'(bus.out_data), 32'h45);
        chk("s_popped", popped, 32'd22);

        // Consumer 3 drops its request after two reads; wrap-around to 0
        bus.req = 4'b1000;
        nc();
        chk("d_gnt", 32'(bus.gnt), 32'h8);
        chk("d_ren0", 32'(bus.r_en), 32'h1);
        nc();
        chk("d_ren1", 32'(bus.r_en), 32'h1);
        nc();
        bus.req = 4'b0111;
        #1;
        chk("d_drop_ren", 32'(bus.r_en), 32'h0);
        chk("d_drop_gnt", 32'(bus.gnt), 32'h8);
        chk("d_last_valid", 32'(bus.out_valid), 32'h1);
        chk("d_last_id", 32'(bus.out_id), 32'h3);
        chk("d_last_data", 32'(bus.out_data), 32'h47);
        nc();
        chk("d_idle_gnt", 32'(bus.gnt), 32'h0);
        chk("d_idle_busy", 32'(bus.busy), 32'h0);
        nc();
        chk("d_wrap_gnt", 32'(bus.gnt), 32'h1);
        chk("d_wrap_ren", 32'(bus.r_en), 32'h1);
        bus.req = 4'b0000;
        nc();
        chk("d_end_gnt", 32'(bus.gnt), 32'h0);
        chk("d_popped", popped, 32'd24);

        // Reset hitting a cycle with r_en asserted
        bus.req = 4'b1000;
        nc();
        chk("r_gnt", 32'(bus.gnt), 32'h8);
        chk("r_ren", 32'(bus.r_en), 32'h1);
        rrst = 1'b1;
        #1;
        chk("r_ren_in_rst", 32'(bus.r_en), 32'h0);
        nc();
        chk("r_valid", 32'(bus.out_valid), 32'h0);
        chk("r_gnt_clr", 32'(bus.gnt), 32'h0);
        chk("r_busy", 32'(bus.busy), 32'h0);
        chk("r_id", 32'(bus.out_id), 32'h0);
        chk("r_popped", popped, 32'd24);
        rrst = 1'b0;
        nc();
        chk("r_first_gnt", 32'(bus.gnt), 32'h8);
        chk("r_first_ren", 32'(bus.r_en), 32'h1);
        bus.req = 4'b0000;
        nc();
        chk("r_end_gnt", 32'(bus.gnt), 32'h0);

        // Randomized traffic with invariant checks
        run_len = 0;
        for (int c = 0; c < 2000; c++) begin
            nc();
            bus.req = 4'($urandom_range(0, 15));
            bus.rdy = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) pushed = pushed + $urandom_range(0, 3);
            #1;
            chk("x_underflow", 32'(bus.r_en && bus.empty), 32'h0);
            chk("x_onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
            if (bus.gnt == 4'b0000) run_len = 0;
            if (bus.r_en) run_len++;
            chk("x_burst_len", 32'(run_len <= 4), 32'h1);
        end
        bus.req = 4'b0000;
        nc();
        nc();
        chk("x_final_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
